// File: rtl/rmii_deframer_pkg.sv
// Shared types and constants for the RMII receive deframer and its CRC helper.
// Holds the state encoding, the preamble/SFD dibit codes and the Ethernet CRC-32 constants.
package rmii_deframer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT   = 2'b01;
  localparam logic [1:0]  SFD_DIBIT        = 2'b11;

  localparam logic [31:0] CRC32_POLYNOMIAL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INITIAL    = 32'hFFFFFFFF;
  // Good-frame residue in conventional (MSB-first) bit order.
  localparam logic [31:0] CRC32_RESIDUE    = 32'hC704DD7B;

  function automatic logic [31:0] bit_reverse32(input logic [31:0] value);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      result[i] = value[31-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Shared by the receive deframer and the transmit framer.
module crc32_byte
  import rmii_deframer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC32_POLYNOMIAL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/rmii_receive_deframer.sv
// RMII receive front end: strips preamble/SFD, assembles bytes into {last, byte} beats,
// and flags each frame good or bad on length and CRC-32 with an end-of-frame pulse.
module rmii_receive_deframer
  import rmii_deframer_pkg::*;
#(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MIN_FRAME_BYTES     = 64,
  parameter int MAX_FRAME_BYTES     = 1518
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] rmii_receive_data,
  input  logic       rmii_receive_data_enable,
  input  logic       rmii_receive_data_error,
  output logic [8:0] receive_data,
  output logic       receive_data_valid,
  output logic       frame_done,
  output logic       frame_error
);

  localparam int BYTE_COUNT_WIDTH     = $clog2(MAX_FRAME_BYTES + 1);
  localparam int PREAMBLE_COUNT_WIDTH = $clog2(MIN_PREAMBLE_DIBITS + 1);

  state_t                          state_reg;
  logic [PREAMBLE_COUNT_WIDTH-1:0] preamble_count_reg;
  logic [PREAMBLE_COUNT_WIDTH-1:0] preamble_count;
  logic [1:0]                      dibit_count_reg;
  logic [5:0]                      shift_reg;
  logic [7:0]                      shift_next;
  logic [BYTE_COUNT_WIDTH-1:0]     byte_count_reg;
  logic [7:0]                      hold_reg;
  logic                            hold_valid_reg;
  logic [31:0]                     crc_reg;
  logic [31:0]                     crc_next;
  logic                            byte_complete;
  logic                            overflow;
  logic                            preamble_met;
  logic                            frame_bad;

  assign shift_next    = {rmii_receive_data, shift_reg};
  assign byte_complete = (dibit_count_reg == 2'd3);
  assign overflow      = byte_complete && (byte_count_reg >= BYTE_COUNT_WIDTH'(MAX_FRAME_BYTES));
  // The dibit that wakes IDLE is judged as the first preamble dibit.
  assign preamble_count = (state_reg == PREAMBLE) ? preamble_count_reg : '0;
  assign preamble_met   = (preamble_count >= PREAMBLE_COUNT_WIDTH'(MIN_PREAMBLE_DIBITS));
  assign frame_bad = (dibit_count_reg != 2'd0)
                  || (byte_count_reg < BYTE_COUNT_WIDTH'(MIN_FRAME_BYTES))
                  || (bit_reverse32(crc_reg) != CRC32_RESIDUE)
                  || !hold_valid_reg;

  crc32_byte u_crc32_byte (
    .crc_in  (crc_reg),
    .data    (shift_next),
    .crc_out (crc_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg          <= IDLE;
      preamble_count_reg <= '0;
      dibit_count_reg    <= '0;
      shift_reg          <= '0;
      byte_count_reg     <= '0;
      hold_reg           <= '0;
      hold_valid_reg     <= 1'b0;
      crc_reg            <= CRC32_INITIAL;
      receive_data       <= '0;
      receive_data_valid <= 1'b0;
      frame_done         <= 1'b0;
      frame_error        <= 1'b0;
    end else begin
      receive_data_valid <= 1'b0;
      frame_done         <= 1'b0;
      frame_error        <= 1'b0;
      case (state_reg)
        IDLE, PREAMBLE: begin
          dibit_count_reg <= '0;
          shift_reg       <= '0;
          byte_count_reg  <= '0;
          hold_valid_reg  <= 1'b0;
          crc_reg         <= CRC32_INITIAL;
          if (!rmii_receive_data_enable) begin
            state_reg          <= IDLE;
            preamble_count_reg <= '0;
          end else if (rmii_receive_data_error) begin
            state_reg <= DROP;
          end else if (rmii_receive_data == PREAMBLE_DIBIT) begin
            state_reg          <= PREAMBLE;
            preamble_count_reg <= preamble_met ? preamble_count : preamble_count + 1'b1;
          end else if (rmii_receive_data == SFD_DIBIT && preamble_met) begin
            state_reg <= DATA;
          end else begin
            state_reg <= DROP;
          end
        end

        DATA: begin
          if (!rmii_receive_data_enable) begin
            state_reg   <= IDLE;
            frame_done  <= 1'b1;
            frame_error <= frame_bad;
            if (hold_valid_reg) begin
              receive_data       <= {1'b1, hold_reg};
              receive_data_valid <= 1'b1;
            end
          end else if (rmii_receive_data_error || overflow) begin
            // Any byte completing in this cycle is discarded.
            state_reg   <= DROP;
            frame_done  <= 1'b1;
            frame_error <= 1'b1;
            if (hold_valid_reg) begin
              receive_data       <= {1'b1, hold_reg};
              receive_data_valid <= 1'b1;
            end
          end else begin
            shift_reg       <= shift_next[7:2];
            dibit_count_reg <= dibit_count_reg + 2'd1;
            if (byte_complete) begin
              crc_reg        <= crc_next;
              hold_reg       <= shift_next;
              hold_valid_reg <= 1'b1;
              if (byte_count_reg < BYTE_COUNT_WIDTH'(MAX_FRAME_BYTES)) begin
                byte_count_reg <= byte_count_reg + 1'b1;
              end
              if (hold_valid_reg) begin
                receive_data       <= {1'b0, hold_reg};
                receive_data_valid <= 1'b1;
              end
            end
          end
        end

        DROP: begin
          if (!rmii_receive_data_enable) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_receive_deframer.sv
// Directed bench for rmii_receive_deframer: frames built with a bench-side FCS,
// beats and end-of-frame status captured by a monitor and compared per frame.
module tb_rmii_receive_deframer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rmii_receive_data = 2'b00;
  logic       rmii_receive_data_enable = 1'b0;
  logic       rmii_receive_data_error = 1'b0;
  logic [8:0] receive_data;
  logic       receive_data_valid;
  logic       frame_done;
  logic       frame_error;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_count  = 0;
  int en_low_cycle = 0;

  logic [7:0] frame_buf [0:1599];
  logic [8:0] beat_q[$];
  int         beat_cyc_q[$];
  logic       done_err_q[$];

  rmii_receive_deframer dut (
    .clock                    (clock),
    .reset                    (reset),
    .rmii_receive_data        (rmii_receive_data),
    .rmii_receive_data_enable (rmii_receive_data_enable),
    .rmii_receive_data_error  (rmii_receive_data_error),
    .receive_data             (receive_data),
    .receive_data_valid       (receive_data_valid),
    .frame_done               (frame_done),
    .frame_error              (frame_error)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cycle_count <= cycle_count + 1;

  always @(negedge clock) begin
    if (receive_data_valid) begin
      beat_q.push_back(receive_data);
      beat_cyc_q.push_back(cycle_count);
    end
    if (frame_done) done_err_q.push_back(frame_error);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] d, input logic en, input logic er);
    rmii_receive_data        = d;
    rmii_receive_data_enable = en;
    rmii_receive_data_error  = er;
    @(posedge clock);
    #1;
  endtask

  task automatic send_preamble(input int n);
    repeat (n) drive(2'b01, 1'b1, 1'b0);
  endtask

  task automatic send_bytes(input int count, input int er_dibit);
    for (int i = 0; i < count; i++) begin
      for (int k = 0; k < 4; k++) begin
        drive(frame_buf[i][2*k +: 2], 1'b1, (i*4 + k) == er_dibit);
      end
    end
  endtask

  task automatic end_frame();
    drive(2'b00, 1'b0, 1'b0);
    en_low_cycle = cycle_count;
    repeat (3) drive(2'b00, 1'b0, 1'b0);
  endtask

  task automatic clear_capture();
    beat_q.delete();
    beat_cyc_q.delete();
    done_err_q.delete();
  endtask

  // Bit-serial reference CRC over frame_buf[0:n-1]; returns the FCS value.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] crc;
    logic        fb;
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb  = crc[0] ^ frame_buf[i][b];
        crc = crc >> 1;
        if (fb) crc = crc ^ 32'hEDB88320;
      end
    end
    return ~crc;
  endfunction

  task automatic build_frame(input int len, input bit corrupt_fcs);
    logic [31:0] fcs;
    for (int i = 0; i < len - 4; i++) frame_buf[i] = 8'($urandom);
    fcs = fcs_of(len - 4);
    for (int j = 0; j < 4; j++) frame_buf[len-4+j] = fcs[8*j +: 8];
    if (corrupt_fcs) frame_buf[63] = frame_buf[63] ^ 8'h01;
  endtask

  task automatic verify(input string name, input int exp_beats, input int exp_done,
                        input logic exp_err, input bit check_timing);
    int         bad;
    logic [8:0] exp_beat;
    bad = 0;
    check({name, "/beats"}, beat_q.size(), exp_beats);
    for (int i = 0; i < beat_q.size() && i < exp_beats; i++) begin
      exp_beat = {(i == exp_beats - 1), frame_buf[i]};
      if (beat_q[i] !== exp_beat) bad++;
    end
    check({name, "/data_mismatches"}, bad, 0);
    check({name, "/frame_done_count"}, done_err_q.size(), exp_done);
    if (exp_done > 0 && done_err_q.size() > 0)
      check({name, "/frame_error"}, done_err_q[0], exp_err);
    if (check_timing && beat_cyc_q.size() > 0)
      check({name, "/last_beat_cycle"}, beat_cyc_q[beat_cyc_q.size()-1], en_low_cycle);
    $display("[TB] frame %s: %0d beats, %0d status pulses", name, beat_q.size(), done_err_q.size());
    clear_capture();
  endtask

  initial begin
    repeat (4) drive(2'b00, 1'b0, 1'b0);
    check("reset/receive_data", receive_data, 9'h000);
    check("reset/valid", receive_data_valid, 1'b0);
    check("reset/frame_done", frame_done, 1'b0);
    check("reset/frame_error", frame_error, 1'b0);
    reset = 1'b0;
    repeat (2) drive(2'b00, 1'b0, 1'b0);
    clear_capture();

    build_frame(64, 1'b0);
    send_preamble(8); drive(2'b11, 1'b1, 1'b0); send_bytes(64, -1); end_frame();
    verify("good64", 64, 1, 1'b0, 1'b1);

    build_frame(64, 1'b1);
    send_preamble(8); drive(2'b11, 1'b1, 1'b0); send_bytes(64, -1); end_frame();
    verify("bad_fcs64", 64, 1, 1'b1, 1'b1);

    build_frame(1518, 1'b0);
    send_preamble(8); drive(2'b11, 1'b1, 1'b0); send_bytes(1518, -1); end_frame();
    verify("good1518", 1518, 1, 1'b0, 1'b1);

    build_frame(1519, 1'b0);
    send_preamble(8); drive(2'b11, 1'b1, 1'b0); send_bytes(1519, -1); end_frame();
    verify("oversize1519", 1518, 1, 1'b1, 1'b0);

    // RX_ER on dibit 2 of byte 20 (global dibit index 77).
    build_frame(64, 1'b0);
    send_preamble(8); drive(2'b11, 1'b1, 1'b0); send_bytes(64, 77); end_frame();
    verify("rx_er_byte20", 19, 1, 1'b1, 1'b0);

    build_frame(64, 1'b0);
    send_preamble(8); drive(2'b11, 1'b1, 1'b0); send_bytes(64, -1); end_frame();
    verify("good_after_rx_er", 64, 1, 1'b0, 1'b1);

    build_frame(64, 1'b0);
    send_preamble(4); drive(2'b11, 1'b1, 1'b0); send_bytes(64, -1); end_frame();
    verify("short_preamble", 0, 0, 1'b0, 1'b0);

    send_preamble(3); drive(2'b00, 1'b1, 1'b0); send_preamble(5);
    drive(2'b11, 1'b1, 1'b0); send_bytes(64, -1); end_frame();
    verify("preamble_00", 0, 0, 1'b0, 1'b0);

    // Reset during byte 30: 28 beats out, then everything abandoned.
    build_frame(64, 1'b0);
    frame_buf[27] = 8'hA5;
    send_preamble(8); drive(2'b11, 1'b1, 1'b0); send_bytes(29, -1);
    drive(frame_buf[29][1:0], 1'b1, 1'b0);
    reset = 1'b1;
    drive(frame_buf[29][3:2], 1'b1, 1'b0);
    check("mid_reset/receive_data", receive_data, 9'h000);
    check("mid_reset/valid", receive_data_valid, 1'b0);
    check("mid_reset/frame_done", frame_done, 1'b0);
    reset = 1'b0;
    repeat (3) drive(2'b00, 1'b0, 1'b0);
    check("mid_reset/beats", beat_q.size(), 28);
    check("mid_reset/frame_done_count", done_err_q.size(), 0);
    $display("[TB] frame mid_reset: %0d beats, %0d status pulses", beat_q.size(), done_err_q.size());
    clear_capture();

    build_frame(64, 1'b0);
    send_preamble(8); drive(2'b11, 1'b1, 1'b0); send_bytes(64, -1); end_frame();
    verify("good_after_reset", 64, 1, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
